// File: rtl/eth_frame_gen_pkg.sv
// Shared types and constants for the Ethernet frame generator: beat geometry,
// frame length limits, generator states and the last-beat keep mask helper.
package eth_frame_gen_pkg;

  localparam int unsigned N_SYMBOLS = 8;
  localparam int unsigned W_SYMBOL  = 8;
  localparam int unsigned W_DATA    = N_SYMBOLS * W_SYMBOL;
  localparam int unsigned W_REM     = $clog2(N_SYMBOLS);
  localparam int unsigned W_LEN     = 16;
  localparam int unsigned W_NFR     = 16;
  localparam int unsigned W_IFG     = 8;
  localparam int unsigned W_BEAT    = 8;
  localparam int unsigned W_FIDX    = 8;

  localparam int unsigned FRAME_MIN_LEN = 60;
  localparam int unsigned FRAME_MAX_LEN = 1514;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } gen_state_t;

  typedef struct packed {
    logic [W_DATA-1:0]    data;
    logic [N_SYMBOLS-1:0] keep;
    logic                 last;
  } axis_beat_t;

  // Byte-enable mask for a final beat holding rem valid bytes (0 means full beat).
  function automatic logic [N_SYMBOLS-1:0] keep_from_len(input logic [W_REM-1:0] rem);
    logic [N_SYMBOLS-1:0] k;
    k = '0;
    for (int unsigned i = 0; i < N_SYMBOLS; i++) begin
      k[i] = (rem == '0) || (i < 32'(rem));
    end
    return k;
  endfunction

endpackage

// File: rtl/eth_frame_gen_if.sv
// AXI-Stream transmit bus between the frame generator and the MAC sink.
interface eth_frame_gen_if;
  import eth_frame_gen_pkg::*;

  logic                 tvalid;
  logic [W_DATA-1:0]    tdata;
  logic [N_SYMBOLS-1:0] tkeep;
  logic                 tlast;
  logic                 tready;

  modport master (output tvalid, output tdata, output tkeep, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tkeep, input tlast, output tready);

endinterface

// File: rtl/eth_frame_gen_prbs.sv
// PRBS-31 (x^31 + x^28 + 1) payload source, 64 bits per step, oldest bit in bit 0.
// i_seed substitutes the all-ones seed for the current state in the same cycle.
module eth_frame_gen_prbs
  import eth_frame_gen_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_seed,
  input  logic              i_adv,
  output logic [W_DATA-1:0] o_word_c
);

  localparam logic [30:0] SEED = 31'h7FFF_FFFF;

  logic [30:0] state_q;
  logic [30:0] cur_c;
  logic [30:0] nxt_c;

  // Unrolled serial LFSR: each generated bit is shifted back into the state.
  always_comb begin
    cur_c    = i_seed ? SEED : state_q;
    nxt_c    = cur_c;
    o_word_c = '0;
    for (int unsigned k = 0; k < W_DATA; k++) begin
      o_word_c[k] = nxt_c[30] ^ nxt_c[27];
      nxt_c       = {nxt_c[29:0], o_word_c[k]};
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= SEED;
    end else if (i_adv) begin
      state_q <= nxt_c;
    end
  end

endmodule

// File: rtl/eth_frame_gen.sv
// Ethernet payload burst generator driving an AXI-Stream MAC transmit sink.
// Define ETH_FRAME_GEN_PRBS_EN for PRBS-31 payload instead of the incrementing pattern.
module eth_frame_gen
  import eth_frame_gen_pkg::*;
#(
  parameter int unsigned MIN_LEN = FRAME_MIN_LEN,
  parameter int unsigned MAX_LEN = FRAME_MAX_LEN,
  parameter int unsigned W_CNT   = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic [W_LEN-1:0] i_len,
  input  logic [W_NFR-1:0] i_n_frames,
  input  logic [W_IFG-1:0] i_ifg,
  output logic             o_busy,
  output logic             o_done,
  output logic [W_CNT-1:0] o_frame_cnt,
  eth_frame_gen_if.master  m_axis
);

  gen_state_t        state_q, state_d;
  logic [W_LEN-1:0]  len_q, len_d;
  logic [W_NFR-1:0]  nfr_q, nfr_d;
  logic [W_IFG-1:0]  ifg_q, ifg_d;
  logic [W_IFG-1:0]  gap_q, gap_d;
  logic [W_BEAT-1:0] beat_q, beat_d;
  logic [W_FIDX-1:0] fidx_q, fidx_d;
  logic [W_NFR-1:0]  sent_q, sent_d;
  logic              stop_q, stop_d;
  logic [W_CNT-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              valid_q, valid_d;
  axis_beat_t        out_q, out_d;

  logic              load_en;
  logic [W_BEAT-1:0] load_beat;
  logic [W_FIDX-1:0] load_fidx;
  logic              clear_out;
  logic [W_LEN-1:0]  len_clamp_c;
  logic [W_LEN-1:0]  last_idx;
  logic [W_DATA-1:0] pat;
  logic [W_NFR-1:0]  sent_inc;
  logic              stop_any;
  logic              hs;

  assign len_clamp_c = (i_len < W_LEN'(MIN_LEN)) ? W_LEN'(MIN_LEN) :
                       (i_len > W_LEN'(MAX_LEN)) ? W_LEN'(MAX_LEN) : i_len;

`ifdef ETH_FRAME_GEN_PRBS_EN
  logic [W_DATA-1:0] prbs_word_c;
  logic              seed_c;

  // Reseed only on burst start; the sequence runs on across frames.
  assign seed_c = (state_q == IDLE) && i_start;

  eth_frame_gen_prbs u_prbs (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_seed   (seed_c),
    .i_adv    (load_en),
    .o_word_c (prbs_word_c)
  );
`endif

  // Next-state logic; registered AXIS outputs are reloaded whenever a new beat is staged.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    nfr_d     = nfr_q;
    ifg_d     = ifg_q;
    gap_d     = gap_q;
    beat_d    = beat_q;
    fidx_d    = fidx_q;
    sent_d    = sent_q;
    stop_d    = stop_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    valid_d   = valid_q;
    out_d     = out_q;
    load_en   = 1'b0;
    load_beat = beat_q;
    load_fidx = fidx_q;
    clear_out = 1'b0;
    last_idx  = '0;
    pat       = '0;
    sent_inc  = sent_q + W_NFR'(1);
    stop_any  = stop_q | i_stop;
    hs        = valid_q & m_axis.tready;

    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          len_d     = len_clamp_c;
          nfr_d     = i_n_frames;
          ifg_d     = i_ifg;
          cnt_d     = '0;
          fidx_d    = '0;
          sent_d    = '0;
          stop_d    = 1'b0;
          state_d   = SEND;
          load_en   = 1'b1;
          load_beat = '0;
          load_fidx = '0;
        end
      end
      SEND: begin
        stop_d = stop_any;
        if (hs) begin
          if (!out_q.last) begin
            load_en   = 1'b1;
            load_beat = beat_q + W_BEAT'(1);
          end else begin
            cnt_d  = cnt_q + W_CNT'(1);
            fidx_d = fidx_q + W_FIDX'(1);
            sent_d = sent_inc;
            if (((nfr_q != '0) && (sent_inc == nfr_q)) || stop_any) begin
              state_d   = IDLE;
              done_d    = 1'b1;
              clear_out = 1'b1;
            end else if (ifg_q == '0) begin
              load_en   = 1'b1;
              load_beat = '0;
              load_fidx = fidx_q + W_FIDX'(1);
            end else begin
              state_d   = GAP;
              gap_d     = ifg_q;
              clear_out = 1'b1;
            end
          end
        end
      end
      GAP: begin
        stop_d = stop_any;
        gap_d  = gap_q - W_IFG'(1);
        if (gap_q == W_IFG'(1)) begin
          if (stop_any) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d   = SEND;
            load_en   = 1'b1;
            load_beat = '0;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        clear_out = 1'b1;
      end
    endcase

    last_idx = W_LEN'((len_d + W_LEN'(N_SYMBOLS - 1)) >> W_REM) - W_LEN'(1);

    if (load_en) begin
      beat_d    = load_beat;
      valid_d   = 1'b1;
      out_d.last = (W_LEN'(load_beat) == last_idx);
      out_d.keep = out_d.last ? keep_from_len(len_d[W_REM-1:0]) : '1;
`ifdef ETH_FRAME_GEN_PRBS_EN
      pat = prbs_word_c;
`else
      for (int unsigned j = 0; j < N_SYMBOLS; j++) begin
        pat[j*W_SYMBOL +: W_SYMBOL] =
          W_SYMBOL'(32'(load_beat) * N_SYMBOLS + j + 32'(load_fidx));
      end
`endif
      for (int unsigned j = 0; j < N_SYMBOLS; j++) begin
        out_d.data[j*W_SYMBOL +: W_SYMBOL] = out_d.keep[j] ? pat[j*W_SYMBOL +: W_SYMBOL] : '0;
      end
    end

    if (clear_out) begin
      valid_d = 1'b0;
      out_d   = '0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      nfr_q   <= '0;
      ifg_q   <= '0;
      gap_q   <= '0;
      beat_q  <= '0;
      fidx_q  <= '0;
      sent_q  <= '0;
      stop_q  <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      nfr_q   <= nfr_d;
      ifg_q   <= ifg_d;
      gap_q   <= gap_d;
      beat_q  <= beat_d;
      fidx_q  <= fidx_d;
      sent_q  <= sent_d;
      stop_q  <= stop_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      out_q   <= out_d;
    end
  end

  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_frame_cnt   = cnt_q;
  assign m_axis.tvalid = valid_q;
  assign m_axis.tdata  = out_q.data;
  assign m_axis.tkeep  = out_q.keep;
  assign m_axis.tlast  = out_q.last;

endmodule

// File: tb/tb_eth_frame_gen.sv
// Directed bench for eth_frame_gen: table of single bursts plus stop and reset sequences.
module tb_eth_frame_gen;
  import eth_frame_gen_pkg::*;

  typedef struct {
    int          len;
    int          n;
    int          ifg;
    bit          rnd;
    int          beats;
    logic [7:0]  keep;
    logic [63:0] last_data;
    int          cnt;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    int          cyc;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start, i_stop;
  logic [15:0] i_len, i_n_frames;
  logic [7:0]  i_ifg;
  logic        o_busy, o_done;
  logic [31:0] o_frame_cnt;

  eth_frame_gen_if axis ();

  eth_frame_gen dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_start     (i_start),
    .i_stop      (i_stop),
    .i_len       (i_len),
    .i_n_frames  (i_n_frames),
    .i_ifg       (i_ifg),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_frame_cnt (o_frame_cnt),
    .m_axis      (axis)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_pass   = 0;
  int    cyc      = 0;
  bit    rnd_ready = 1'b0;
  beat_t q[$];
  vec_t  vecs[6];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  // Ready driver, updated just after each rising edge.
  initial begin
    axis.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1 axis.tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Beat monitor and stall-stability checker, sampled on the falling edge.
  initial begin
    bit          stall_prev;
    logic [63:0] held_data;
    logic [8:0]  held_kl;
    stall_prev = 1'b0;
    held_data  = '0;
    held_kl    = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("stall_valid", 64'(axis.tvalid), 64'd1);
          check("stall_data", axis.tdata, held_data);
          check("stall_keep_last", 64'({axis.tkeep, axis.tlast}), 64'(held_kl));
        end
        if (axis.tvalid && axis.tready)
          q.push_back('{data: axis.tdata, keep: axis.tkeep, last: axis.tlast, cyc: cyc});
        stall_prev = axis.tvalid && !axis.tready;
        held_data  = axis.tdata;
        held_kl    = {axis.tkeep, axis.tlast};
      end
    end
  end

  function automatic int clamp_len(int len);
    if (len < 60) return 60;
    if (len > 1514) return 1514;
    return len;
  endfunction

  // Reference stream: lane j of beat b in frame f is (8b+j+f) mod 256, zero past the end.
  function automatic int model_mism(int len);
    int          f, b, nb, mism;
    logic [63:0] ed;
    logic [7:0]  ek;
    f = 0; b = 0; mism = 0;
    nb = (len + 7) / 8;
    foreach (q[i]) begin
      ed = '0; ek = '0;
      for (int j = 0; j < 8; j++) begin
        if (8 * b + j < len) begin
          ek[j] = 1'b1;
          ed[8*j +: 8] = 8'((8 * b + j + f) % 256);
        end
      end
      if (q[i].data !== ed || q[i].keep !== ek || q[i].last !== (b == nb - 1)) mism++;
      if (b == nb - 1) begin f++; b = 0; end
      else b++;
    end
    return mism;
  endfunction

  task automatic start_burst(input int len, input int n, input int ifg);
    @(posedge clk);
    #1;
    i_len      = 16'(len);
    i_n_frames = 16'(n);
    i_ifg      = 8'(ifg);
    i_start    = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    @(negedge clk);
    check("start_valid", 64'(axis.tvalid), 64'd1);
    check("start_busy", 64'(o_busy), 64'd1);
  endtask

  task automatic wait_done(input int budget, output bit ok, output int dcyc, output logic [31:0] dcnt);
    ok = 1'b0; dcyc = 0; dcnt = '0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (o_done) begin
        ok = 1'b1; dcyc = cyc; dcnt = o_frame_cnt;
        break;
      end
    end
    check("done_seen", 64'(ok), 64'd1);
    if (ok) begin
      check("busy_at_done", 64'(o_busy), 64'd0);
      @(negedge clk);
      check("done_pulse_width", 64'(o_done), 64'd0);
    end
  endtask

  task automatic run_vec(input vec_t v);
    bit          ok;
    int          dcyc;
    logic [31:0] dcnt;
    q.delete();
    rnd_ready = v.rnd;
    start_burst(v.len, v.n, v.ifg);
    wait_done(4000, ok, dcyc, dcnt);
    rnd_ready = 1'b0;
    check($sformatf("beats_len%0d", v.len), 64'(q.size()), 64'(v.beats * v.n));
    if (q.size() >= v.beats) begin
      check($sformatf("last_keep_len%0d", v.len), 64'(q[v.beats-1].keep), 64'(v.keep));
      check($sformatf("last_data_len%0d", v.len), q[v.beats-1].data, v.last_data);
      check($sformatf("last_flag_len%0d", v.len), 64'(q[v.beats-1].last), 64'd1);
    end
    check($sformatf("stream_mism_len%0d", v.len), 64'(model_mism(clamp_len(v.len))), 64'd0);
    check($sformatf("frame_cnt_len%0d", v.len), 64'(dcnt), 64'(v.cnt));
    if (ok && q.size() > 0) check("done_latency", 64'(dcyc), 64'(q[$].cyc + 1));
    if (!v.rnd) begin
      for (int i = 0; i + 1 < q.size(); i++) begin
        if (q[i].last) check("ifg_gap", 64'(q[i+1].cyc - q[i].cyc), 64'(v.ifg + 1));
      end
    end
  endtask

  initial begin
    bit          ok;
    int          dcyc;
    logic [31:0] dcnt;

    vecs[0] = '{len: 64,   n: 1, ifg: 0, rnd: 1'b0, beats: 8,   keep: 8'hFF, last_data: 64'h3F3E3D3C3B3A3938, cnt: 1};
    vecs[1] = '{len: 61,   n: 1, ifg: 0, rnd: 1'b0, beats: 8,   keep: 8'h1F, last_data: 64'h0000003C3B3A3938, cnt: 1};
    vecs[2] = '{len: 10,   n: 1, ifg: 0, rnd: 1'b0, beats: 8,   keep: 8'h0F, last_data: 64'h000000003B3A3938, cnt: 1};
    vecs[3] = '{len: 2000, n: 1, ifg: 0, rnd: 1'b0, beats: 190, keep: 8'h03, last_data: 64'h000000000000E9E8, cnt: 1};
    vecs[4] = '{len: 64,   n: 3, ifg: 4, rnd: 1'b0, beats: 8,   keep: 8'hFF, last_data: 64'h3F3E3D3C3B3A3938, cnt: 3};
    vecs[5] = '{len: 100,  n: 2, ifg: 2, rnd: 1'b1, beats: 13,  keep: 8'h0F, last_data: 64'h0000000063626160, cnt: 2};

    rst = 1'b1; i_start = 1'b0; i_stop = 1'b0;
    i_len = '0; i_n_frames = '0; i_ifg = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 64'(axis.tvalid), 64'd0);
    check("rst_tdata", axis.tdata, 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_frame_cnt", 64'(o_frame_cnt), 64'd0);
    rst = 1'b0;

    // Stop raised in IDLE must not start anything.
    i_stop = 1'b1;
    repeat (3) @(posedge clk);
    #1 i_stop = 1'b0;
    check("idle_stop_busy", 64'(o_busy), 64'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Continuous burst stopped mid-frame 5; a start while busy is ignored.
    q.delete();
    start_burst(64, 0, 0);
    for (int k = 0; k < 200 && q.size() < 43; k++) @(negedge clk);
    check("cont_reached_frame5", 64'(q.size() >= 43), 64'd1);
    @(posedge clk);
    #1;
    i_stop = 1'b1; i_start = 1'b1; i_len = 16'd100; i_n_frames = 16'd1;
    @(posedge clk);
    #1 i_stop = 1'b0; i_start = 1'b0;
    wait_done(400, ok, dcyc, dcnt);
    check("stop_frame_cnt", 64'(dcnt), 64'd6);
    check("stop_beats", 64'(q.size()), 64'd48);
    check("stop_stream_mism", 64'(model_mism(64)), 64'd0);
    if (q.size() == 48) begin
      check("b2b_span", 64'(q[47].cyc - q[0].cyc), 64'd47);
      check("stop_last", 64'(q[47].last), 64'd1);
      if (ok) check("stop_done_latency", 64'(dcyc), 64'(q[47].cyc + 1));
    end

    // Reset in the middle of a frame, then a fresh burst restarts the pattern.
    q.delete();
    start_burst(64, 1, 0);
    for (int k = 0; k < 50 && q.size() < 3; k++) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_tvalid", 64'(axis.tvalid), 64'd0);
    check("midrst_tdata", axis.tdata, 64'd0);
    check("midrst_tkeep_tlast", 64'({axis.tkeep, axis.tlast}), 64'd0);
    check("midrst_busy_done", 64'({o_busy, o_done}), 64'd0);
    check("midrst_frame_cnt", 64'(o_frame_cnt), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    run_vec(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/eth_frame_gen.md
Name: eth_frame_gen

Overview:
- AXI-Stream traffic source that drives the MAC transmit sink interface (s_axis_* of custom_mac_pcs). It is the transmitting end of that stream.
- Generates bursts of Ethernet payload frames with software-set length, count and inter-frame gap, and a deterministic payload.
- Used in loopback benches and on-board self-test, paired with a checker on the MAC receive stream.

Parameters:
- N_SYMBOLS, 8, bytes per beat
- W_SYMBOL, 8, bits per byte
- MIN_LEN, 60, minimum frame length in bytes (pre-FCS)
- MAX_LEN, 1514, maximum frame length in bytes (pre-FCS)
- W_CNT, 32, width of frame counter

Ports:
- i_clk  in  1  single clock
- i_reset  in  1  asynchronous, active-high reset
- i_start  in  1  one-cycle request to begin a burst; sampled only in IDLE
- i_stop  in  1  level; finish current frame, then return to IDLE
- i_len  in  16  frame length in bytes
- i_n_frames  in  16  frames per burst; 0 = continuous until i_stop
- i_ifg  in  8  idle cycles between frames
- o_busy  out  1  high whenever state != IDLE
- o_done  out  1  one-cycle pulse when burst completes
- o_frame_cnt  out  W_CNT  frames completed since last i_start
- m_axis_tvalid  out  1  AXIS valid
- m_axis_tdata  out  N_SYMBOLS*W_SYMBOL  AXIS data, byte 0 in bits [7:0]
- m_axis_tkeep  out  N_SYMBOLS  AXIS byte enables
- m_axis_tlast  out  1  last beat of frame
- m_axis_tready  in  1  AXIS ready from MAC

Behaviour:
- Reset (async assert, release on the next i_clk edge): state IDLE; all outputs 0.
- States: IDLE, SEND, GAP.
- IDLE:
  - On i_start, latch L = clamp(i_len, MIN_LEN, MAX_LEN), i_n_frames and i_ifg.
  - Clear o_frame_cnt and set frame index f = 0.
  - Go to SEND; the first beat is valid on the next cycle (1-cycle latency).
- i_start while busy: ignored.
- SEND:
  - Beats per frame B = ceil(L/8).
  - Byte lane j of beat b = (8b + j + f) mod 256.
  - tkeep is 0xFF on all beats except the last. On the last beat it is the (L mod 8) LSBs set, or 0xFF if L mod 8 = 0. Lanes with tkeep = 0 drive 0x00.
  - tlast is high on beat B-1 only.
  - Beat advances only on tvalid && tready.
  - While tvalid && !tready, tdata/tkeep/tlast are held stable and tvalid is never dropped.
- After the tlast handshake:
  - o_frame_cnt increments (wraps at 2^W_CNT) and f increments (mod 256).
  - The burst is complete if (n_frames != 0 and frames sent == n_frames), or if i_stop was high at any point during the frame.
  - Burst complete: pulse o_done, go to IDLE.
  - Otherwise, if ifg = 0: next frame's beat 0 is presented on the following cycle (back-to-back).
  - Otherwise: go to GAP.
- GAP: tvalid = 0 for exactly ifg cycles, then SEND.
- i_stop asserted in GAP: burst ends at the end of GAP with o_done pulse; no further frame.
- i_stop asserted in IDLE: no effect.
- Reset mid-frame: tvalid drops asynchronously with no tlast; the downstream MAC is reset with it.
- Counters: beat counter is 8 bits (MAX_LEN/8 < 256). Frames-sent counter is 16 bits.

Optional Feature:
- ETH_FRAME_GEN_PRBS_EN defined: payload comes from a PRBS-31 (x^31 + x^28 + 1) advanced 64 bits per accepted beat. Byte 0 is the oldest bits.
  - Seeded to 0x7FFFFFFF at each i_start; not reseeded per frame.
  - tkeep masking and zeroing of unused lanes still apply.
- Undefined: incrementing pattern as specified above.

Decomposition:
- Shared package mac_params:
  - gen_state_t enum {IDLE, SEND, GAP}
  - constants FRAME_MIN_LEN = 60 and FRAME_MAX_LEN = 1514
  - function keep_from_len(rem) returning the N_SYMBOLS-bit mask
- Reuse N_SYMBOLS and W_SYMBOL from cmn_params.
- One sub-module, eth_frame_gen_prbs: combinational 64-bit-parallel PRBS-31 step plus state register. Instantiated only under ETH_FRAME_GEN_PRBS_EN.

Test Plan:
- len=64, n=1, ifg=0, tready=1
  - 8 beats, tkeep 0xFF on all, bytes 0x00..0x3F, tlast on beat 7.
  - o_done pulses the cycle after beat 7; o_frame_cnt=1.
- len=61, n=1
  - 8 beats, last beat tkeep 0x1F.
  - Last beat lanes 0-4 = 0x38..0x3C, lanes 5-7 = 0x00.
- len=10 -> clamped to 60: 8 beats, last tkeep 0x0F.
- len=2000 -> clamped to 1514: 190 beats, last tkeep 0x03.
- len=64, n=3, ifg=4: tvalid low exactly 4 cycles between frames; frame 1 starts 0x01, frame 2 starts 0x02; o_frame_cnt=3.
- Random 50% tready, len=100, n=2: outputs stable while stalled; byte stream matches the model.
- n=0, ifg=0: continuous back-to-back frames.
  - Raise i_stop mid-frame 5: frame 5 completes with tlast, o_done, IDLE; o_frame_cnt=6.
- Assert i_reset at beat 3 of a frame: tvalid=0 immediately, all outputs 0.
  - A fresh i_start restarts at byte 0x00.
